// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns and BCD codes shared by the 7-segment scan decoder
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_BAD   = 4'hE;

    // One flag per nibble of a four-digit frame, set where the digit is unrecognised.
    function automatic logic [3:0] bad_flags(input logic [15:0] frame);
        logic [3:0] flags;
        flags = 4'b0000;
        for (int i = 0; i < 4; i++)
            flags[i] = (frame[4*i +: 4] == BCD_BAD);
        return flags;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational segment-pattern to BCD lookup
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd
);

    always_comb begin
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: bcd = BCD_BLANK;
            default:   bcd = BCD_BAD;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - debounced capture of a scanned 4-digit 7-segment display into BCD frames
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  dig_en,
    output logic [15:0] bcd,
    output logic [3:0]  bad,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun
);

    localparam logic [3:0] CAP_AT = 4'(STABLE_CYCLES - 1);

    logic [6:0]  seg_r, seg_p;
    logic [3:0]  dig_r, dig_p;
    logic [3:0]  count, count_nxt;
    logic [3:0]  seen;
    logic [15:0] slots;
    logic [3:0]  dec;
    logic        dig_onehot, same, capture, frame_done, xfer;

    seg7_to_bcd u_seg7_to_bcd (
        .seg (seg_r),
        .bcd (dec)
    );

    assign dig_onehot = $onehot(dig_r);
    assign same       = ({dig_r, seg_r} == {dig_p, seg_p});

    always_comb begin
        count_nxt = 4'd0;
        if (same && dig_onehot)
            count_nxt = (count == 4'hF) ? count : count + 4'd1;
    end

    // CAP_AT never exceeds 14, so the count passes through it once per stable run.
    assign capture    = dig_onehot && (count_nxt == CAP_AT);
    assign frame_done = &seen;
    assign xfer       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= 7'd0;
            dig_r <= 4'd0;
            seg_p <= 7'd0;
            dig_p <= 4'd0;
            count <= 4'd0;
            seen  <= 4'd0;
            slots <= {4{BCD_BLANK}};
        end else begin
            seg_r <= seg;
            dig_r <= dig_en;
            seg_p <= seg_r;
            dig_p <= dig_r;
            count <= count_nxt;
            seen  <= (frame_done ? 4'd0 : seen) | (capture ? dig_r : 4'd0);
            for (int i = 0; i < 4; i++)
                if (capture && dig_r[i])
                    slots[4*i +: 4] <= dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd       <= {4{BCD_BLANK}};
            bad       <= 4'd0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                bcd       <= slots;
                bad       <= bad_flags(slots);
                out_valid <= 1'b1;
                overrun   <= out_valid && !out_ready;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    localparam int S = 4;

    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1111011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        out_ready;
    logic [15:0] bcd;
    logic [3:0]  bad;
    logic        out_valid;
    logic        overrun;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .dig_en    (dig_en),
        .bcd       (bcd),
        .bad       (bad),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cycles, ovr_count;
    logic [15:0] last_bcd;
    logic [3:0]  last_bad;

    logic [6:0] pat [10];

    // reference model: run length of identical one-hot pin values drives captures
    logic [3:0]  m_slot [4];
    logic [3:0]  m_seen;
    logic [15:0] m_bcd;
    logic [3:0]  m_bad;
    logic        m_valid, m_ovr;
    int          run, cap_idx;
    logic [10:0] last_pins;
    logic        cap_pend;
    logic [3:0]  cap_val;

    typedef struct packed {
        logic [27:0] pats;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_bad;
    } frame_vec_t;

    frame_vec_t vecs [4];

    function automatic logic [3:0] ref_decode(input logic [6:0] s);
        if (s == 7'b0000000)
            return 4'hF;
        for (int v = 0; v < 10; v++)
            if (s == pat[v])
                return 4'(v);
        return 4'hE;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++)
            m_slot[i] = 4'hF;
        m_seen    = 4'd0;
        m_bcd     = 16'hFFFF;
        m_bad     = 4'd0;
        m_valid   = 1'b0;
        m_ovr     = 1'b0;
        run       = 0;
        last_pins = 11'd0;
        cap_pend  = 1'b0;
        cap_idx   = 0;
        cap_val   = 4'hF;
    endtask

    task automatic model_edge(input logic [6:0] s, input logic [3:0] d, input logic r);
        logic ld;
        ld    = (m_seen == 4'hF);
        m_ovr = ld && m_valid && !r;
        if (ld) begin
            m_valid = 1'b1;
            m_seen  = 4'd0;
            for (int i = 0; i < 4; i++) begin
                m_bcd[4*i +: 4] = m_slot[i];
                m_bad[i]        = (m_slot[i] == 4'hE);
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        if (cap_pend) begin
            m_slot[cap_idx] = cap_val;
            m_seen[cap_idx] = 1'b1;
        end
        if ($onehot(d) && ({d, s} == last_pins))
            run++;
        else
            run = $onehot(d) ? 1 : 0;
        last_pins = {d, s};
        cap_pend  = (run == S);
        cap_idx   = 0;
        for (int i = 0; i < 4; i++)
            if (d[i])
                cap_idx = i;
        cap_val = ref_decode(s);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n)
            model_edge(seg, dig_en, out_ready);
        else
            model_reset();
        #1;
        chk("bcd", bcd, m_bcd);
        chk("bad", 16'(bad), 16'(m_bad));
        chk("out_valid", 16'(out_valid), 16'(m_valid));
        chk("overrun", 16'(overrun), 16'(m_ovr));
        if (out_valid) begin
            valid_cycles++;
            last_bcd = bcd;
            last_bad = bad;
        end
        if (overrun)
            ovr_count++;
    endtask

    task automatic scan(input int idx, input logic [6:0] p, input int hold);
        dig_en = 4'b0001 << idx;
        seg    = p;
        repeat (hold) tick();
    endtask

    task automatic idle(input int n);
        dig_en = 4'd0;
        seg    = 7'd0;
        repeat (n) tick();
    endtask

    task automatic clear_counts();
        valid_cycles = 0;
        ovr_count    = 0;
        last_bcd     = 16'hxxxx;
        last_bad     = 4'hx;
    endtask

    task automatic scan_frame(input logic [6:0] p0, input logic [6:0] p1,
                              input logic [6:0] p2, input logic [6:0] p3);
        scan(0, p0, 6);
        scan(1, p1, 6);
        scan(2, p2, 6);
        scan(3, p3, 6);
    endtask

    initial begin
        int r, hold;
        pat = '{P0, P1, P2, P3, P4, P5, P6, P7, P8, P9};
        vecs[0] = '{pats: {P4, P3, P2, P1}, exp_bcd: 16'h4321, exp_bad: 4'b0000};
        vecs[1] = '{pats: {7'b1000001, P9, 7'b0000000, P7}, exp_bcd: 16'hE9F7, exp_bad: 4'b1000};
        vecs[2] = '{pats: {P8, P6, P5, P0}, exp_bcd: 16'h8650, exp_bad: 4'b0000};
        vecs[3] = '{pats: {7'b0000000, 7'b1100000, P3, 7'b0000001}, exp_bcd: 16'hFE3E, exp_bad: 4'b0101};

        model_reset();
        clear_counts();
        rst_n     = 1'b0;
        seg       = 7'd0;
        dig_en    = 4'd0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("reset_bcd", bcd, 16'hFFFF);
        chk("reset_bad", 16'(bad), 16'h0);
        chk("reset_valid", 16'(out_valid), 16'h0);
        chk("reset_overrun", 16'(overrun), 16'h0);
        rst_n = 1'b1;
        idle(3);

        // frame table: basic frame, blank/bad digits, mixed patterns
        for (int v = 0; v < 4; v++) begin
            clear_counts();
            for (int i = 0; i < 4; i++)
                scan(i, vecs[v].pats[7*i +: 7], 6);
            idle(3);
            chk("vec_valid_cycles", 16'(valid_cycles), 16'd1);
            chk("vec_bcd", last_bcd, vecs[v].exp_bcd);
            chk("vec_bad", 16'(last_bad), 16'(vecs[v].exp_bad));
            chk("vec_overruns", 16'(ovr_count), 16'd0);
        end

        // glitch: a short-lived 3 on digit 2 must be rejected
        clear_counts();
        scan(0, P1, 6);
        scan(1, P2, 6);
        scan(2, P3, 2);
        scan(2, P5, 6);
        scan(3, P4, 6);
        idle(3);
        chk("glitch_valid_cycles", 16'(valid_cycles), 16'd1);
        chk("glitch_bcd", last_bcd, 16'h4521);

        // backpressure across two frames
        out_ready = 1'b0;
        clear_counts();
        scan_frame(P1, P2, P3, P4);
        scan(0, P5, 6);
        scan(1, P6, 6);
        scan(2, P7, 6);
        chk("bp_first_held", bcd, 16'h4321);
        chk("bp_first_valid", 16'(out_valid), 16'd1);
        scan(3, P8, 6);
        idle(4);
        chk("bp_valid", 16'(out_valid), 16'd1);
        chk("bp_bcd", bcd, 16'h8765);
        chk("bp_overruns", 16'(ovr_count), 16'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_release", 16'(out_valid), 16'd0);
        idle(3);

        // frame load coincides with the transfer of a pending frame
        out_ready = 1'b0;
        scan_frame(P1, P2, P3, P4);
        clear_counts();
        scan(0, P5, 6);
        scan(1, P6, 6);
        scan(2, P7, 6);
        scan(3, P8, 5);
        chk("sim_pending_bcd", bcd, 16'h4321);
        out_ready = 1'b1;
        tick();
        chk("sim_valid", 16'(out_valid), 16'd1);
        chk("sim_bcd", bcd, 16'h8765);
        chk("sim_overruns", 16'(ovr_count), 16'd0);
        tick();
        chk("sim_drain", 16'(out_valid), 16'd0);
        idle(3);

        // reset with three digits captured
        scan(0, P1, 6);
        scan(1, P2, 6);
        scan(2, P3, 6);
        rst_n = 1'b0;
        #2;
        chk("async_rst_bcd", bcd, 16'hFFFF);
        chk("async_rst_valid", 16'(out_valid), 16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        clear_counts();
        scan(3, P4, 6);
        idle(5);
        chk("rst_partial_valid", 16'(valid_cycles), 16'd0);
        scan_frame(P1, P2, P3, P4);
        idle(3);
        chk("rst_rescan_valid", 16'(valid_cycles), 16'd1);
        chk("rst_rescan_bcd", last_bcd, 16'h4321);

        // randomized scanning against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)
                dig_en = 4'($urandom_range(0, 15));
            else
                dig_en = 4'b0001 << (n % 4);
            if ($urandom_range(0, 4) == 0)
                seg = 7'($urandom);
            else
                seg = pat[$urandom_range(0, 9)];
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            if (n == 200) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 1..15: consecutive identical samples needed to accept a digit.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port seg, input, 7: segment lines {a,b,c,d,e,f,g}, bit 6 = a, active-high.
REQ-005 SHALL have port dig_en, input, 4: digit strobes, active-high, one-hot when valid; bit 0 = digit 0 (least significant).
REQ-006 SHALL have port bcd, output, 16: decoded frame, digit i in bits [4i+3:4i].
REQ-007 SHALL have port bad, output, 4: per-digit flag; bit i set when digit i decoded to 4'hE.
REQ-008 SHALL have port out_valid, output, 1: bcd/bad hold a frame not yet accepted.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts the frame.
REQ-010 SHALL have port overrun, output, 1: one-cycle pulse when an unaccepted frame is overwritten.

Function
REQ-011 SHALL register seg and dig_en once; all further logic uses only the registered copies.
REQ-012 SHALL decode patterns 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011 to 0-9; 0000000 to 4'hF (blank, not bad); any other pattern to 4'hE (bad).
REQ-013 SHALL keep a saturating 4-bit stability count: +1 when registered {dig_en,seg} equals the previous registered value and dig_en is one-hot; otherwise cleared to 0.
REQ-014 SHALL capture the decoded digit into slot i (i = one-hot index of dig_en) and set seen[i] on the edge where the count first reaches STABLE_CYCLES-1; this is one capture per stable run, repeated only after the count clears.
REQ-015 SHALL treat dig_en = 0000 or multiple bits set as a blanking interval: no capture, count cleared.
REQ-016 SHALL recapture a slot already seen in the current frame, with the newest value winning.
REQ-017 SHALL complete a frame when seen = 1111: on the next edge load bcd/bad from the slots, set out_valid, and clear seen.
REQ-018 SHALL give latency: with pins held from before edge k, the capture occurs at edge k+STABLE_CYCLES; if that capture completes the frame, out_valid is high after edge k+STABLE_CYCLES+1.
REQ-019 SHALL transfer when out_valid and out_ready are both high; out_valid drops on the next edge unless a new frame loads on that edge.
REQ-020 SHALL hold bcd, bad and out_valid stable while out_valid=1 and out_ready=0, except under REQ-021.
REQ-021 SHALL, when a frame loads while out_valid=1 and no transfer occurs that edge, overwrite bcd/bad, keep out_valid=1, and pulse overrun for one cycle.
REQ-022 SHALL, when load and transfer happen on the same edge, load the new frame, keep out_valid=1, and not pulse overrun.
REQ-023 SHALL ignore out_ready while out_valid=0.

Reset
REQ-024 SHALL on rst_n low asynchronously clear: input registers, count, seen, slots (to 4'hF), bcd=16'hFFFF, bad=0, out_valid=0, overrun=0.
REQ-025 SHALL, on reset mid-frame, discard the partial frame; the first frame after release requires all four digits to be captured again.

Structure
REQ-026 SHALL place the segment constants SEG_0..SEG_9 and SEG_BLANK, plus BCD_BLANK=4'hF and BCD_BAD=4'hE, in shared package seg7_pkg.
REQ-027 SHALL implement the REQ-012 table as one combinational sub-module, seg7_to_bcd (7-bit in, 4-bit out), instantiated once.

Verification
REQ-028 SHALL test a basic frame: scan digits 0..3 with patterns for 1,2,3,4, each held 6 cycles, out_ready=1 -> bcd=16'h4321, bad=0, one out_valid cycle.
REQ-029 SHALL test glitch rejection: digit 2 shows 1111001 for 2 cycles, then 1011011 for 6 cycles -> bcd[11:8]=5, never 3.
REQ-030 SHALL test blank and bad patterns: digit 1 = 0000000, digit 3 = 1000001 -> bcd[7:4]=F, bcd[15:12]=E, bad=1000.
REQ-031 SHALL test backpressure: out_ready=0 over two complete frames (1234 then 5678) -> overrun pulses once, bcd=16'h8765 held until out_ready=1.
REQ-032 SHALL test a simultaneous event: the frame load edge coincides with out_ready=1 on a pending frame -> no overrun, out_valid stays 1, new data is visible.
REQ-033 SHALL test reset mid-frame: reset after digits 0-2 are captured, then scan only digit 3 -> out_valid stays 0; a full rescan then produces a frame.
